wb_lsu_master: RTL and testbench

Wishbone classic initiator that serves the core's load/store unit. It accepts one memory request at a time on a valid/ready handshake and issues a single Wishbone cycle. For loads it aligns and sign- or zero-extends the returned word; every request ends in exactly one response carrying the data or an error. It is the initiator counterpart to the word-addressed peripherals on the same bus, including the timer.

---
 rtl/wb_lsu_master.sv | 173 +++++++++++++++++
 tb/tb_wb_lsu_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_lsu_master.sv
// Wishbone classic initiator for the load/store unit: one request in flight, aligned/extended load data, retry and optional timeout (WB_TIMEOUT_EN).
// Zero-wait slave: accept at T0, STB in T0+1, resp_valid in T0+2; req_ready low until the response cycle has passed.
module wb_lsu_master #(
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_misaligned,
    output logic        CYC,
    output logic        STB,
    output logic        WE,
    output logic [31:0] ADR,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic [3:0]  SEL,
    output logic [2:0]  CTI_O,
    input  logic        ACK,
    input  logic        ERR,
    input  logic        RTY
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUS     = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;
    localparam int RW = $clog2(MAX_RETRY + 2);

    logic [1:0]    state;
    logic          stb_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [RW-1:0] retry_cnt;
    logic          err_q;
    logic          mis_q;
    logic [31:0]   rdata_q;
    logic          tmo_hit;

    logic        mis_n;
    logic [3:0]  sel_n;
    logic [31:0] dat_n;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        mis_n = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (|req_addr[1:0]));
        case (req_size)
            2'b00:   begin sel_n = 4'b0001 << req_addr[1:0]; dat_n = {4{req_wdata[7:0]}};  end
            2'b01:   begin sel_n = 4'b0011 << req_addr[1:0]; dat_n = {2{req_wdata[15:0]}}; end
            default: begin sel_n = 4'b1111;                  dat_n = req_wdata;             end
        endcase
    end

    always_comb begin
        ld_byte = DAT_I[{off_q, 3'b000} +: 8];
        ld_half = DAT_I[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = DAT_I;
        endcase
    end

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts only cycles with STB high; the setup cycle and BACKOFF keep it at zero.
    always_ff @(posedge clk) begin
        if (rst || state != S_BUS || !stb_q) begin
            tmo_cnt <= '0;
        end else if (!(ACK | ERR | RTY)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0 & (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            stb_q     <= 1'b0;
            WE        <= 1'b0;
            ADR       <= '0;
            SEL       <= '0;
            DAT_O     <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            retry_cnt <= '0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        WE      <= req_we;
                        ADR     <= {req_addr[31:2], 2'b00};
                        SEL     <= sel_n;
                        DAT_O   <= dat_n;
                        off_q   <= req_addr[1:0];
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        err_q   <= 1'b0;
                        mis_q   <= mis_n;
                        rdata_q <= '0;
                        state   <= mis_n ? S_RESP : S_BUS;
                    end
                end
                S_BUS: begin
                    // First BUS cycle after acceptance only raises STB; terminations count once STB is up.
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                    end else if (ERR) begin
                        stb_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else if (ACK) begin
                        stb_q <= 1'b0;
                        if (!WE) rdata_q <= ld_ext;
                        state <= S_RESP;
                    end else if (RTY) begin
                        stb_q <= 1'b0;
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= S_BACKOFF;
                        end else begin
                            err_q <= 1'b1;
                            state <= S_RESP;
                        end
                    end else if (tmo_hit) begin
                        stb_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end
                end
                S_BACKOFF: begin
                    stb_q <= 1'b1;
                    state <= S_BUS;
                end
                default: begin
                    retry_cnt <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = (state == S_IDLE) & ~rst;
    assign CYC             = stb_q;
    assign STB             = stb_q;
    assign CTI_O           = 3'b000;
    assign resp_valid      = (state == S_RESP);
    assign resp_rdata      = resp_valid ? rdata_q : 32'h0;
    assign resp_err        = resp_valid & err_q;
    assign resp_misaligned = resp_valid & mis_q;
endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a zero-wait Wishbone slave model scripted per test.
module tb_wb_lsu_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err, resp_misaligned;
    logic [31:0] resp_rdata;
    logic        CYC, STB, WE, ACK, ERR, RTY;
    logic [31:0] ADR, DAT_O, DAT_I;
    logic [3:0]  SEL;
    logic [2:0]  CTI_O;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          sl_rty;
    bit          sl_err, sl_silent;
    int          stb_cnt;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;

    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_err, r_mis, r_seen;

    wb_lsu_master #(.MAX_RETRY(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_misaligned(resp_misaligned),
        .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .DAT_O(DAT_O), .DAT_I(DAT_I),
        .SEL(SEL), .CTI_O(CTI_O), .ACK(ACK), .ERR(ERR), .RTY(RTY)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave: answers during every STB cycle, terminations are presented away from the clock edge.
    always @(negedge clk) begin
        ACK = 1'b0; ERR = 1'b0; RTY = 1'b0;
        if (STB === 1'b1) begin
            stb_cnt++;
            cap_adr = ADR; cap_sel = SEL; cap_dat = DAT_O; cap_we = WE;
            if (!sl_silent) begin
                if (sl_err) ERR = 1'b1;
                if (sl_rty > 0) begin
                    RTY = 1'b1;
                    sl_rty--;
                end else begin
                    ACK = 1'b1;
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns);
        int a;
        @(negedge clk);
        stb_cnt = 0;
        check("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk);
        #1;
        a = cyc;
        req_valid = 1'b0;
        r_seen = 1'b0;
        for (int i = 0; i < 100 && !r_seen; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                r_seen = 1'b1; r_lat = cyc - a;
                r_rdata = resp_rdata; r_err = resp_err; r_mis = resp_misaligned;
            end
        end
        check("resp_seen", r_seen, 1'b1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_unsigned = 1'b0; DAT_I = '0;
        sl_rty = 0; sl_err = 1'b0; sl_silent = 1'b0; stb_cnt = 0;
        ACK = 1'b0; ERR = 1'b0; RTY = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", CYC, 1'b0);
        check("rst_stb", STB, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_adr", ADR, 32'h0);
        rst = 1'b0;

        DAT_I = 32'h1234_5678;
        do_req(1'b0, 32'h0000_1008, 32'h0, 2'b10, 1'b0);
        check("wl_adr", cap_adr, 32'h0000_1008);
        check("wl_sel", cap_sel, 4'b1111);
        check("wl_we", cap_we, 1'b0);
        check("wl_rdata", r_rdata, 32'h1234_5678);
        check("wl_err", r_err, 1'b0);
        check("wl_lat", r_lat, 2);
        check("wl_stbs", stb_cnt, 1);

        DAT_I = 32'h8000_0000;
        do_req(1'b0, 32'h0000_2003, 32'h0, 2'b00, 1'b0);
        check("bs_sel", cap_sel, 4'b1000);
        check("bs_adr", cap_adr, 32'h0000_2000);
        check("bs_rdata", r_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 32'h0000_2003, 32'h0, 2'b00, 1'b1);
        check("bu_rdata", r_rdata, 32'h0000_0080);

        DAT_I = 32'hCAFE_1234;
        do_req(1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b0);
        check("hs_sel", cap_sel, 4'b1100);
        check("hs_rdata", r_rdata, 32'hFFFF_CAFE);

        do_req(1'b1, 32'h0000_3002, 32'h0000_BEEF, 2'b01, 1'b0);
        check("st_sel", cap_sel, 4'b1100);
        check("st_dat", cap_dat, 32'hBEEF_BEEF);
        check("st_we", cap_we, 1'b1);
        check("st_err", r_err, 1'b0);
        check("st_rdata", r_rdata, 32'h0);

        do_req(1'b0, 32'h0000_4001, 32'h0, 2'b10, 1'b0);
        check("mis_flag", r_mis, 1'b1);
        check("mis_lat", r_lat, 0);
        check("mis_nobus", stb_cnt, 0);
        do_req(1'b0, 32'h0000_4000, 32'h0, 2'b11, 1'b0);
        check("ill_flag", r_mis, 1'b1);

        sl_rty = 5;
        do_req(1'b0, 32'h0000_5000, 32'h0, 2'b10, 1'b0);
        check("rty5_err", r_err, 1'b1);
        check("rty5_stbs", stb_cnt, 5);
        check("rty5_lat", r_lat, 10);
        sl_rty = 0;

        DAT_I = 32'h0BAD_F00D;
        sl_rty = 2;
        do_req(1'b0, 32'h0000_5004, 32'h0, 2'b10, 1'b0);
        check("rty2_err", r_err, 1'b0);
        check("rty2_rdata", r_rdata, 32'h0BAD_F00D);
        check("rty2_stbs", stb_cnt, 3);
        check("rty2_lat", r_lat, 6);
        sl_rty = 0;

        sl_err = 1'b1;
        do_req(1'b0, 32'h0000_6000, 32'h0, 2'b10, 1'b0);
        check("ackerr_err", r_err, 1'b1);
        check("ackerr_rdata", r_rdata, 32'h0);
        sl_err = 1'b0;

`ifdef WB_TIMEOUT_EN
        sl_silent = 1'b1;
        do_req(1'b0, 32'h0000_7000, 32'h0, 2'b10, 1'b0);
        check("tmo_err", r_err, 1'b1);
        check("tmo_stbs", stb_cnt, 8);
        sl_silent = 1'b0;
`endif

        // Reset in the middle of a bus cycle with a slave that never answers.
        sl_silent = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_8000; req_size = 2'b10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_seen = 1'b0;
        for (int i = 0; i < 20 && !r_seen; i++) begin
            @(negedge clk);
            if (STB === 1'b1) r_seen = 1'b1;
        end
        check("rstmid_stb_up", r_seen, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_cyc", CYC, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        r_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) r_seen = 1'b1;
        end
        check("rstmid_noresp", r_seen, 1'b0);
        check("rstmid_ready", req_ready, 1'b1);
        sl_silent = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
